// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: issues word fetches under a credit limit,
// tags returned words with their PC, buffers them in a small FIFO and
// discards wrong-path responses after a redirect.
//
// Optional build macro: IFU_PERF_EN adds perf_fetch_cnt / perf_flush_cnt.
//
// state | meaning
// RUN   | normal fetch; responses are pushed into the FIFO
// DRAIN | waiting out wrong-path responses; no requests issued
module ifu_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_discard;
  logic [CW-1:0]   w_discard_nxt;
  logic [CW-1:0]   w_discard_redir;

  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_resp_pc;
  logic [CW-1:0]   r_outstanding;

  logic [31:0]     r_fifo_pc   [DEPTH];
  logic [31:0]     r_fifo_data [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic [SW-1:0]   w_inflight;
  logic            w_acc;
  logic            w_resp_hit;
  logic            w_push;
  logic            w_pop;
  logic [31:0]     w_redirect_pc;

  // Credit covers both buffered words and words still in flight, so a
  // response can never find the FIFO full.
  assign w_inflight    = SW'(r_count) + SW'(r_outstanding);
  assign mem_req_valid = !rst && (r_state == ST_RUN) && (w_inflight < SW'(DEPTH));
  assign mem_req_addr  = r_fetch_pc;
  assign w_acc         = mem_req_valid && mem_req_ready;

  // A response only counts if something is owed: outstanding in RUN,
  // discard in DRAIN. Anything else is a stray beat and is ignored.
  assign w_resp_hit = mem_resp_valid &&
                      ((r_state == ST_RUN) ? (r_outstanding != '0) : (r_discard != '0));
  assign w_push     = w_resp_hit && (r_state == ST_RUN) && !redirect_valid;

  assign inst_valid = (r_count != '0);
  assign inst_pc    = r_fifo_pc[r_rd_ptr];
  assign inst_data  = r_fifo_data[r_rd_ptr];
  assign w_pop      = inst_valid && inst_ready;

  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

  // In RUN discard is zero and in DRAIN outstanding is zero, so one sum
  // gives the wrong-path count for a redirect in either state.
  assign w_discard_redir = r_discard + r_outstanding + CW'(w_acc) - CW'(w_resp_hit);

  // Next-state and discard bookkeeping; redirect overrides everything.
  always_comb begin
    w_state_nxt   = r_state;
    w_discard_nxt = r_discard;
    if (redirect_valid) begin
      w_discard_nxt = w_discard_redir;
      w_state_nxt   = (w_discard_redir != '0) ? ST_DRAIN : ST_RUN;
    end else if (r_state == ST_DRAIN) begin
      if (w_resp_hit) begin
        w_discard_nxt = r_discard - CW'(1);
        if (r_discard == CW'(1)) begin
          w_state_nxt = ST_RUN;
        end
      end else if (r_discard == '0) begin
        w_state_nxt = ST_RUN;
      end
    end
  end

  // FSM state and discard counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_discard <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_discard <= w_discard_nxt;
    end
  end

  // Fetch/response PCs and the outstanding-request count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc    <= w_redirect_pc;
      r_resp_pc     <= w_redirect_pc;
      r_outstanding <= '0;
    end else begin
      if (w_acc) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + 32'd4;
      end
      r_outstanding <= r_outstanding + CW'(w_acc) - CW'(w_push);
    end
  end

  // Instruction FIFO with first-word fall-through; flushed on redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_fifo_pc[i]   <= RESET_PC;
        r_fifo_data[i] <= '0;
      end
    end else if (redirect_valid) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
        r_fifo_data[r_wr_ptr] <= mem_resp_data;
        r_wr_ptr              <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

`ifdef IFU_PERF_EN
  // Free-running event counters: accepted fetches and redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (w_acc) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (redirect_valid) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch. The memory is modelled inside tick():
// accepted addresses are queued and answered in order, one per cycle when
// auto_resp is set, with data = ~address so data can be tied back to PC.
module tb_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        auto_resp = 1'b1;
  logic [31:0] q[$];
  logic [31:0] acc_log[$];

  ifu_prefetch #(.DEPTH(4), .RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data)
`ifdef IFU_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // One clock cycle: sample the handshake before the edge, then update
  // the memory model and drive the next response 1 time unit after it.
  task automatic tick();
    logic        acc;
    logic        r;
    logic [31:0] a;
    #1;
    acc = mem_req_valid && mem_req_ready;
    a   = mem_req_addr;
    r   = rst;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
    end else begin
      if (acc) begin
        q.push_back(a);
        acc_log.push_back(a);
      end
      if (auto_resp && q.size() != 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = ~q.pop_front();
      end else begin
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
      end
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b0;
    inst_ready     = 1'b0;
    auto_resp      = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    acc_log.delete();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %b exp 0", mem_req_valid); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid got %b exp 0", inst_valid); end
    n_checks++; if (mem_req_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_req_addr got %h exp 80000000", mem_req_addr); end
    n_checks++; if (inst_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_inst_pc got %h exp 80000000", inst_pc); end
    n_checks++; if (inst_data !== 32'h0) begin n_fail++; $display("FAIL reset_inst_data got %h exp 0", inst_data); end
    rst = 1'b0;
    #1;
    n_checks++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL release_req_valid got %b exp 1", mem_req_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    mem_req_ready = 1'b1;
    inst_ready    = 1'b1;
    #1;
    n_checks++; if (mem_req_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL stream_first_addr got %h exp 80000000", mem_req_addr); end
    tick();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL stream_latency1 inst_valid got %b exp 0", inst_valid); end
    n_checks++; if (mem_req_addr !== 32'h8000_0004) begin n_fail++; $display("FAIL stream_second_addr got %h exp 80000004", mem_req_addr); end
    tick();
    exp_pc = 32'h8000_0000;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst_data !== ~exp_pc) begin
        n_fail++;
        $display("FAIL stream_inst[%0d] got v=%b pc=%h d=%h exp v=1 pc=%h d=%h", k, inst_valid, inst_pc, inst_data, exp_pc, ~exp_pc);
      end
      exp_pc = exp_pc + 32'd4;
      tick();
    end
    n_checks++; if (acc_log.size() != 10 || acc_log[3] !== 32'h8000_000C) begin n_fail++; $display("FAIL stream_accepts got n=%0d a3=%h exp n=10 a3=8000000c", acc_log.size(), acc_log[3]); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    do_reset();
    mem_req_ready = 1'b1;
    inst_ready    = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    n_checks++; if (acc_log.size() != 4) begin n_fail++; $display("FAIL bp_accept_count got %0d exp 4", acc_log.size()); end
    n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_blocked got %b exp 0", mem_req_valid); end
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL bp_head got v=%b pc=%h exp v=1 pc=80000000", inst_valid, inst_pc); end
    inst_ready = 1'b1;
    exp_pc = 32'h8000_0000;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst_data !== ~exp_pc) begin
        n_fail++;
        $display("FAIL bp_drain[%0d] got v=%b pc=%h exp v=1 pc=%h", k, inst_valid, inst_pc, exp_pc);
      end
      exp_pc = exp_pc + 32'd4;
      tick();
    end
    n_checks++; if (acc_log.size() < 5 || acc_log[4] !== 32'h8000_0010) begin n_fail++; $display("FAIL bp_resume_addr got n=%0d exp 5th addr 80000010", acc_log.size()); end
  endtask

  task automatic test_req_stall();
    logic ok;
    do_reset();
    inst_ready    = 1'b1;
    mem_req_ready = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000) ok = 1'b0;
    end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_hold got v=%b a=%h exp v=1 a=80000000", mem_req_valid, mem_req_addr); end
    mem_req_ready = 1'b1;
    tick();
    n_checks++; if (acc_log.size() != 1 || acc_log[0] !== 32'h8000_0000) begin n_fail++; $display("FAIL stall_accept got n=%0d exp 1 at 80000000", acc_log.size()); end
    n_checks++; if (mem_req_addr !== 32'h8000_0004) begin n_fail++; $display("FAIL stall_next_addr got %h exp 80000004", mem_req_addr); end
  endtask

  task automatic test_redirect_drain();
    int first;
    int seen;
    do_reset();
    mem_req_ready = 1'b1;
    inst_ready    = 1'b0;
    auto_resp     = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL drain_credit_full got %b exp 0", mem_req_valid); end
    auto_resp = 1'b1;
    tick();
    auto_resp = 1'b0;
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL drain_pre_head got v=%b pc=%h exp v=1 pc=80000000", inst_valid, inst_pc); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_1002;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL drain_flush got %b exp 0", inst_valid); end
    n_checks++; if (mem_req_addr !== 32'h8000_1000) begin n_fail++; $display("FAIL drain_new_addr got %h exp 80001000", mem_req_addr); end
    auto_resp  = 1'b1;
    inst_ready = 1'b1;
    first = 0;
    for (int i = 1; i <= 8 && first == 0; i++) begin
      tick();
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL drain_stale_inst[%0d] got pc=%h exp none", i, inst_pc); end
      if (mem_req_valid === 1'b1) first = i;
    end
    n_checks++; if (first != 4) begin n_fail++; $display("FAIL drain_resume_cycle got %0d exp 4", first); end
    n_checks++; if (mem_req_addr !== 32'h8000_1000) begin n_fail++; $display("FAIL drain_resume_addr got %h exp 80001000", mem_req_addr); end
    seen = 0;
    for (int i = 0; i < 6 && seen == 0; i++) begin
      tick();
      if (inst_valid === 1'b1) seen = i + 1;
    end
    n_checks++; if (seen != 2 || inst_pc !== 32'h8000_1000 || inst_data !== ~32'h8000_1000) begin n_fail++; $display("FAIL drain_first_inst got t=%0d pc=%h d=%h exp t=2 pc=80001000", seen, inst_pc, inst_data); end
  endtask

  task automatic test_redirect_collide();
    logic [31:0] exp_pc;
    int          n_deliv;
    do_reset();
    mem_req_ready = 1'b1;
    inst_ready    = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    n_checks++; if (mem_req_valid !== 1'b1 || inst_valid !== 1'b1 || inst_pc !== 32'h8000_0008) begin n_fail++; $display("FAIL collide_pre got rv=%b iv=%b pc=%h exp 1 1 80000008", mem_req_valid, inst_valid, inst_pc); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF9;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (inst_valid !== 1'b0 || mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL collide_drain got iv=%b rv=%b exp 0 0", inst_valid, mem_req_valid); end
    tick();
    n_checks++; if (inst_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL collide_resume got iv=%b rv=%b a=%h exp 0 1 fffffff8", inst_valid, mem_req_valid, mem_req_addr); end
    exp_pc  = 32'hFFFF_FFF8;
    n_deliv = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (inst_valid === 1'b1) begin
        n_checks++;
        if (inst_pc !== exp_pc || inst_data !== ~exp_pc) begin
          n_fail++;
          $display("FAIL collide_inst[%0d] got pc=%h d=%h exp pc=%h", n_deliv, inst_pc, inst_data, exp_pc);
        end
        exp_pc  = exp_pc + 32'd4;
        n_deliv = n_deliv + 1;
      end
    end
    n_checks++; if (n_deliv != 7) begin n_fail++; $display("FAIL collide_deliv_count got %0d exp 7", n_deliv); end
  endtask

`ifdef IFU_PERF_EN
  task automatic test_perf();
    do_reset();
    n_checks++; if (perf_fetch_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin n_fail++; $display("FAIL perf_reset got %0d %0d exp 0 0", perf_fetch_cnt, perf_flush_cnt); end
    mem_req_ready = 1'b1;
    inst_ready    = 1'b1;
    for (int i = 0; i < 40 && acc_log.size() < 10; i++) tick();
    mem_req_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      tick();
      redirect_valid = 1'b0;
      for (int k = 0; k < 3; k++) tick();
    end
    n_checks++; if (perf_fetch_cnt !== 32'd10) begin n_fail++; $display("FAIL perf_fetch got %0d exp 10", perf_fetch_cnt); end
    n_checks++; if (perf_flush_cnt !== 32'd2) begin n_fail++; $display("FAIL perf_flush got %0d exp 2", perf_flush_cnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (perf_fetch_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin n_fail++; $display("FAIL perf_rst got %0d %0d exp 0 0", perf_fetch_cnt, perf_flush_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_req_stall();
    test_redirect_drain();
    test_redirect_collide();
`ifdef IFU_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
